led_spawner: RTL and testbench

Request initiator for the LED timer bank: periodically picks a pseudo-random free LED and issues a one-cycle `led_request` with `led_index`. It drives the request side of the LED timer interface and uses the bank's LED outputs as `led_busy` feedback, so it never targets an LED that is already lit. It sits between game control (`enable`) and the LED timer bank.

---
 rtl/led_game_pkg.sv | 19 +
 rtl/lfsr16.sv | 35 +++
 rtl/led_spawner.sv | 143 ++++++++++++++
 tb/tb_led_spawner.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/led_game_pkg.sv
// Shared constants and types for the LED game blocks.
//   LED_COUNT_DEF : default number of LEDs in the bank
//   LED_IDX_W     : width of an LED index
//   LFSR_W/MASK   : width and Galois feedback mask of the game LFSR
//   spawn_state_e : request-initiator FSM states
package led_game_pkg;

  localparam int unsigned LED_COUNT_DEF = 18;
  localparam int unsigned LED_IDX_W     = 5;
  localparam int unsigned LFSR_W        = 16;
  localparam logic [LFSR_W-1:0] LFSR_MASK = 16'hB400;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    PICK = 2'd2
  } spawn_state_e;

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit right-shifting Galois LFSR, advances every clock.
//   clk, rst_n : clock, async active-low reset (state returns to SEED)
//   state_o    : current LFSR state
module lfsr16
  import led_game_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [LFSR_W-1:0] state_o
);

  logic [LFSR_W-1:0] state_q;
  logic [LFSR_W-1:0] state_d;

  // Shift right; when a 1 falls out of bit 0, fold it back through the mask.
  always_comb begin
    state_d = {1'b0, state_q[LFSR_W-1:1]};
    if (state_q[0]) begin
      state_d = state_d ^ LFSR_MASK;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SEED;
    end else begin
      state_q <= state_d;
    end
  end

  assign state_o = state_q;

endmodule

// File: rtl/led_spawner.sv
// LED request initiator: every SPAWN_CYCLES picks a pseudo-random free LED
// and issues a one-cycle request to the LED timer bank.
//   clk, rst_n   : clock, async active-low reset
//   enable       : spawning runs while high
//   led_busy     : per-LED lit status from the timer bank
//   led_index    : index of the last issued request (held between requests)
//   led_request  : one-cycle request pulse, led_index valid alongside
//   skip         : one-cycle pulse when an attempt found no free LED
//   spawn_count  : saturating count of issued requests
module led_spawner
  import led_game_pkg::*;
#(
  parameter int unsigned       LED_COUNT    = LED_COUNT_DEF,
  parameter int unsigned       SPAWN_CYCLES = 20_000_000,
  parameter int unsigned       MAX_TRIES    = 8,
  parameter logic [LFSR_W-1:0] LFSR_SEED    = 16'hACE1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic [LED_COUNT-1:0] led_busy,
  output logic [LED_IDX_W-1:0] led_index,
  output logic                 led_request,
  output logic                 skip,
  output logic [15:0]          spawn_count
);

  localparam int unsigned CNT_W = (SPAWN_CYCLES > 1) ? $clog2(SPAWN_CYCLES) : 1;
  localparam int unsigned TRY_W = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(SPAWN_CYCLES - 1);
  localparam logic [TRY_W-1:0] TRY_LAST   = TRY_W'(MAX_TRIES - 1);

  logic [LFSR_W-1:0]    lfsr;
  logic                 lfsr_unused;
  logic [LED_IDX_W-1:0] cand;
  logic [31:0]          busy_ext;
  logic                 cand_valid;

  spawn_state_e         state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [TRY_W-1:0]     tries_q, tries_d;
  logic [LED_IDX_W-1:0] led_index_q, led_index_d;
  logic                 led_request_q, led_request_d;
  logic                 skip_q, skip_d;
  logic [15:0]          spawn_count_q, spawn_count_d;

  lfsr16 #(
    .SEED    (LFSR_SEED)
  ) u_lfsr (
    .clk     (clk),
    .rst_n   (rst_n),
    .state_o (lfsr)
  );

  // Only the low bits pick an LED; the rest only feed the LFSR itself.
  assign lfsr_unused = ^lfsr[LFSR_W-1:LED_IDX_W];
  assign cand        = lfsr[LED_IDX_W-1:0];

  // Zero-extend so out-of-range candidates never index past the bank.
  assign busy_ext   = 32'(led_busy);
  assign cand_valid = (32'(cand) < LED_COUNT) && !busy_ext[cand];

  // Next-state and output decode; pulses default low every cycle.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    tries_d       = tries_q;
    led_index_d   = led_index_q;
    led_request_d = 1'b0;
    skip_d        = 1'b0;
    spawn_count_d = spawn_count_q;

    if (!enable) begin
      // Dropping enable abandons any request or skip decided this cycle.
      state_d = IDLE;
      cnt_d   = '0;
      tries_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = WAIT;
          cnt_d   = CNT_RELOAD;
          tries_d = '0;
        end
        WAIT: begin
          if (cnt_q == '0) begin
            state_d = PICK;
            tries_d = '0;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        PICK: begin
          if (cand_valid) begin
            led_index_d   = cand;
            led_request_d = 1'b1;
            spawn_count_d = (spawn_count_q == 16'hFFFF) ? spawn_count_q
                                                        : spawn_count_q + 16'd1;
            state_d       = WAIT;
            cnt_d         = CNT_RELOAD;
          end else if (tries_q == TRY_LAST) begin
            skip_d  = 1'b1;
            state_d = WAIT;
            cnt_d   = CNT_RELOAD;
          end else begin
            tries_d = tries_q + TRY_W'(1);
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
          tries_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      tries_q       <= '0;
      led_index_q   <= '0;
      led_request_q <= 1'b0;
      skip_q        <= 1'b0;
      spawn_count_q <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      tries_q       <= tries_d;
      led_index_q   <= led_index_d;
      led_request_q <= led_request_d;
      skip_q        <= skip_d;
      spawn_count_q <= spawn_count_d;
    end
  end

  assign led_index   = led_index_q;
  assign led_request = led_request_q;
  assign skip        = skip_q;
  assign spawn_count = spawn_count_q;

endmodule

// File: tb/tb_led_spawner.sv
// Self-checking bench for led_spawner (SPAWN_CYCLES=4, LED_COUNT=18).
// Instance a uses MAX_TRIES=8, instance b uses MAX_TRIES=64.
module tb_led_spawner;

  localparam int unsigned N_LED = 18;
  localparam logic [15:0] SEED  = 16'hACE1;
  localparam int          HIST_N = 4096;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [17:0] led_busy = '0;

  logic [4:0]  a_idx, b_idx, m_idx;
  logic        a_req, b_req, m_req;
  logic        a_skip, b_skip, m_skip;
  logic [15:0] a_cnt, b_cnt, m_cnt;
  bit          use_b = 1'b0;

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          exp_cnt = 0;
  int          n_skip = 0;
  logic [15:0] lfsr_m = SEED;
  logic [15:0] hist [HIST_N];

  always #5 clk = ~clk;

  led_spawner #(
    .LED_COUNT(N_LED), .SPAWN_CYCLES(4), .MAX_TRIES(8), .LFSR_SEED(SEED)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .enable(enable), .led_busy(led_busy),
    .led_index(a_idx), .led_request(a_req), .skip(a_skip), .spawn_count(a_cnt)
  );

  led_spawner #(
    .LED_COUNT(N_LED), .SPAWN_CYCLES(4), .MAX_TRIES(64), .LFSR_SEED(SEED)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .enable(enable), .led_busy(led_busy),
    .led_index(b_idx), .led_request(b_req), .skip(b_skip), .spawn_count(b_cnt)
  );

  always_comb begin
    m_idx  = use_b ? b_idx  : a_idx;
    m_req  = use_b ? b_req  : a_req;
    m_skip = use_b ? b_skip : a_skip;
    m_cnt  = use_b ? b_cnt  : a_cnt;
  end

  function automatic logic [15:0] step(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
  endfunction

  function automatic bit cand_ok(input logic [4:0] c);
    logic [31:0] b;
    b = 32'(led_busy);
    return (int'(c) < N_LED) && !b[c];
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: reference LFSR advances with the DUT, sample at the falling edge.
  task automatic tick();
    lfsr_m = step(lfsr_m);
    @(posedge clk);
    cyc++;
    if (cyc >= HIST_N) begin
      $display("FAIL cycle_budget: got %0d, expected < %0d", cyc, HIST_N);
      $fatal(1, "cycle budget exhausted");
    end
    hist[cyc] = lfsr_m;
    @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    rst_n    = 1'b0;
    enable   = 1'b0;
    led_busy = '0;
    repeat (n) begin
      @(negedge clk);
      chk("reset_outputs", int'({a_idx, a_req, a_skip, a_cnt}), 0);
    end
    rst_n     = 1'b1;
    lfsr_m    = SEED;
    hist[cyc] = SEED;
    exp_cnt   = 0;
  endtask

  // Runs n cycles with enable high; attempt i begins at the edge after pulse i-1.
  task automatic run_mon(input int n, input int max_tries);
    int p;
    int c;
    int bad;
    p      = cyc + 1;
    n_skip = 0;
    enable = 1'b1;
    for (int i = 0; i < n; i++) begin
      tick();
      c = cyc;
      if (m_req && m_skip) chk("req_and_skip_together", 1, 0);
      if (m_req) begin
        bad = 0;
        for (int j = p + 4; j <= c - 2; j++) if (cand_ok(hist[j][4:0])) bad++;
        chk("req_gap_at_least_5", int'(c - p >= 5), 1);
        chk("req_index_vs_lfsr", int'(m_idx), int'(hist[c-1][4:0]));
        chk("req_index_free", int'(cand_ok(m_idx)), 1);
        chk("req_passed_free_draw", bad, 0);
        chk("req_within_tries", int'((c - 1) - (p + 4) < max_tries), 1);
        exp_cnt++;
        chk("req_spawn_count", int'(m_cnt), exp_cnt);
        p = c;
      end else if (m_skip) begin
        bad = 0;
        for (int j = p + 4; j <= c - 1; j++) if (cand_ok(hist[j][4:0])) bad++;
        chk("skip_pick_cycles", c - (p + 4), max_tries);
        chk("skip_missed_free_draw", bad, 0);
        n_skip++;
        p = c;
      end else if (c - p >= 4 + max_tries) begin
        chk("pulse_overdue", c - p, 4 + max_tries - 1);
        p = c;
      end
    end
  endtask

  typedef struct {
    logic        en;
    logic [17:0] busy;
    logic        req;
    logic        skp;
    logic [4:0]  idx;
    logic [15:0] cnt;
  } vec_t;

  vec_t tbl [27];

  initial begin
    int got;

    // Per-cycle vectors from a fresh reset; row k drives edge k and checks after it.
    // Draws by cycle: s5=7, s10=17, s11=24, s12=12, s17=17, s23=22, s24=27, s25=29, s26=14.
    for (int i = 0; i < 27; i++) begin
      tbl[i].en   = 1'b1;
      tbl[i].busy = '0;
      tbl[i].req  = 1'b0;
      tbl[i].skp  = 1'b0;
      tbl[i].idx  = (i < 5) ? 5'd0 : (i < 12) ? 5'd7 : (i < 26) ? 5'd12 : 5'd14;
      tbl[i].cnt  = (i < 5) ? 16'd0 : (i < 12) ? 16'd1 : (i < 26) ? 16'd2 : 16'd3;
    end
    tbl[5].req   = 1'b1;
    tbl[10].busy = 18'h20000;
    tbl[12].req  = 1'b1;
    tbl[17].en   = 1'b0;
    tbl[26].req  = 1'b1;

    // Reset and long idle
    do_reset(3);
    for (int i = 0; i < 100; i++) begin
      tick();
      chk("idle_outputs", int'({a_idx, a_req, a_skip, a_cnt}), 0);
    end

    // Directed table
    do_reset(2);
    for (int i = 0; i < 27; i++) begin
      enable   = tbl[i].en;
      led_busy = tbl[i].busy;
      tick();
      chk($sformatf("tbl%0d_req", i + 1), int'(a_req), int'(tbl[i].req));
      chk($sformatf("tbl%0d_skip", i + 1), int'(a_skip), int'(tbl[i].skp));
      chk($sformatf("tbl%0d_idx", i + 1), int'(a_idx), int'(tbl[i].idx));
      chk($sformatf("tbl%0d_cnt", i + 1), int'(a_cnt), int'(tbl[i].cnt));
    end

    // Free run, all LEDs free
    do_reset(2);
    run_mon(200, 8);
    chk("free_count_final", int'(a_cnt), exp_cnt);
    chk("free_enough_requests", int'(exp_cnt >= 10), 1);

    // Only LED 7 free, MAX_TRIES=64
    do_reset(2);
    led_busy = 18'h3FF7F;
    use_b    = 1'b1;
    run_mon(300, 64);
    chk("single_free_count", int'(b_cnt), exp_cnt);
    chk("single_free_last_idx", int'(exp_cnt == 0 || b_idx == 5'd7), 1);
    use_b = 1'b0;

    // All busy: skips only, first 12 edges after the enabling edge, then every 12
    do_reset(2);
    led_busy = 18'h3FFFF;
    run_mon(120, 8);
    chk("all_busy_count", int'(a_cnt), 0);
    chk("all_busy_skips", n_skip, 9);

    // Enable dropped in the second WAIT cycle
    do_reset(2);
    enable = 1'b1;
    tick();
    tick();
    enable = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick();
      chk("disabled_no_pulse", int'({a_req, a_skip}), 0);
    end
    run_mon(40, 8);
    chk("reenable_count", int'(a_cnt), exp_cnt);

    // Async reset in the middle of a PICK cycle
    do_reset(2);
    enable = 1'b1;
    got    = 0;
    for (int i = 0; i < 20 && got == 0; i++) begin
      tick();
      if (a_req) got = 1;
    end
    chk("async_first_req_seen", got, 1);
    led_busy = 18'h3FFFF;
    repeat (4) tick();
    chk("async_count_before", int'(a_cnt), 1);
    rst_n = 1'b0;
    #1;
    chk("async_outputs_cleared", int'({a_idx, a_req, a_skip, a_cnt}), 0);
    @(negedge clk);
    @(negedge clk);
    chk("async_held_in_reset", int'({a_idx, a_req, a_skip, a_cnt}), 0);
    rst_n     = 1'b1;
    lfsr_m    = SEED;
    hist[cyc] = SEED;
    exp_cnt   = 0;
    led_busy  = '0;
    run_mon(40, 8);
    chk("async_resume_count", int'(a_cnt), exp_cnt);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
